m_fetch_queue: RTL and testbench
================================

# m_fetch_queue

Instruction fetch stage with a prefetch queue, sitting directly upstream of the decode/register-read stage of the single-issue RV32 core. It owns the PC, reads the asynchronous instruction memory every cycle the queue has room, and buffers {pc, instruction} pairs in a small FIFO. Decode consumes them through a valid/ready handshake. A redirect port lets the execute stage restart fetch at a new PC and discard everything queued.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2
- RESET_PC, 32'h0, PC loaded on reset
- w_clk  in  1  clock; all state updates on posedge
- w_rst  in  1  reset, synchronous, active-high
- w_imem_addr  out  32  address to async instruction memory; equals current PC
- w_imem_data  in  32  instruction returned combinationally for w_imem_addr
- w_redir  in  1  redirect request from execute
- w_redir_pc  in  32  redirect target; bits [1:0] ignored (treated as 0)
- w_valid  out  1  head entry present
- w_ready  in  1  decode accepts head this cycle
- w_ir  out  32  head instruction; 32'h0 when empty
- w_pc  out  32  PC of head instruction; 32'h0 when empty
- w_count  out  log2(DEPTH)+1  current occupancy

## Operation
- State: PC register, DEPTH-entry storage of {pc, ir}, read pointer, write pointer, occupancy count.
- Pop = w_valid & w_ready & ~w_redir.
- Push = ~w_redir & ((count < DEPTH) | pop). On push, entry {PC, w_imem_data} is written at the write pointer, and PC <= PC + 4.
- Simultaneous push and pop on a full queue is allowed: count stays DEPTH.
- Simultaneous push and pop on an empty queue cannot occur, because pop requires w_valid. The push lands and count becomes 1.
- Count update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Pointers wrap modulo DEPTH.
- PC arithmetic is modulo 2^32; 32'hFFFFFFFC + 4 = 32'h0.
- Redirect (w_redir = 1):
  - count, read pointer and write pointer clear to 0.
  - PC <= {w_redir_pc[31:2], 2'b00}.
  - No push and no pop that cycle, regardless of w_ready.
- w_valid = (count != 0). w_ir and w_pc are driven from the head entry, and forced to 0 when empty.
- Reset priority: w_rst > w_redir > push/pop.
- Reset values:
  - PC = RESET_PC; count = 0; pointers = 0.
  - Outputs: w_valid = 0, w_ir = 0, w_pc = 0, w_count = 0, w_imem_addr = RESET_PC.

## Timing
- Memory read is combinational, within the same cycle as the PC.
- Fetch-to-decode latency is 1 cycle: an instruction fetched in cycle n is visible on w_ir in cycle n+1. There is no bypass path from memory to output.
- After reset deasserts at edge E, the first fetch is at RESET_PC in the cycle following E, and w_valid rises one cycle after that.
- After redirect is sampled at edge R:
  - w_valid = 0 in the cycle after R.
  - The first target instruction is fetched in the cycle after R.
  - It appears on w_ir two cycles after R.
- Sustained throughput is one instruction per cycle with w_ready held high.
- Reset asserted mid-stream discards all entries at that edge; redirect input is ignored during reset.
- w_ready may toggle freely. w_ir and w_pc hold stable while w_valid = 1 and w_ready = 0.

## Configuration
- FETCH_STALL_CNT_EN:
  - When defined, adds output w_stall_cnt (32 bits).
  - It increments by 1 every cycle with w_ready = 1, w_valid = 0, w_redir = 0 and w_rst = 0.
  - It clears on reset, is not cleared by redirect, and wraps at 2^32.
- When undefined, the port and counter do not exist; all other behaviour is identical.

## Test plan
- Reset then stream: RESET_PC = 0, w_ready = 1, memory returns addr ^ 32'hA5A50000.
  - w_valid rises the cycle after first fetch.
  - w_pc sequence is 0, 4, 8, …, one per cycle.
  - w_ir matches the memory pattern; w_count stays 1.
- Backpressure: w_ready = 0 for 10 cycles.
  - w_count climbs to 4 and stops; w_imem_addr holds at 16; w_ir holds at the addr-0 instruction.
  - Then w_ready = 1: pops 0, 4, 8, 12, 16 in consecutive cycles with no gap.
- Full with simultaneous push/pop: queue full, w_ready = 1 for one cycle.
  - count stays 4; head advances 0 → 4; PC advances 16 → 20.
- Redirect: mid-stream, w_redir = 1 with w_redir_pc = 32'h103 while full.
  - Next cycle: w_valid = 0, w_count = 0, w_imem_addr = 32'h100.
  - One cycle later: w_pc = 32'h100.
  - No pre-redirect entry is ever popped after the redirect edge.
- Reset vs redirect and PC wrap:
  - w_rst and w_redir both high: PC = RESET_PC.
  - Redirect to 32'hFFFFFFF8: w_pc sequence is FFFFFFF8, FFFFFFFC, 0, 4.
- Stall counter (FETCH_STALL_CNT_EN defined):
  - After reset with w_ready = 1, w_stall_cnt = 1 after the first empty cycle.
  - Each redirect adds exactly 1.

Source files
------------

// File: rtl/m_fetch_queue.sv
// Instruction fetch stage: owns the PC, reads async imem and buffers {pc, ir} in a DEPTH-entry queue.
// Optional FETCH_STALL_CNT_EN adds w_stall_cnt, counting cycles decode was ready but the queue was empty.
module m_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                     w_clk,
    input  logic                     w_rst,
    output logic [31:0]              w_imem_addr,
    input  logic [31:0]              w_imem_data,
    input  logic                     w_redir,
    input  logic [31:0]              w_redir_pc,
    output logic                     w_valid,
    input  logic                     w_ready,
    output logic [31:0]              w_ir,
    output logic [31:0]              w_pc,
    output logic [$clog2(DEPTH):0]   w_count
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [31:0]              w_stall_cnt
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   ent_pc_q [DEPTH];
    logic [31:0]   ent_ir_q [DEPTH];
    logic [31:0]   ent_pc_d [DEPTH];
    logic [31:0]   ent_ir_d [DEPTH];

    logic          pop;
    logic          push;
    logic          unused_redir_lsb;

    assign unused_redir_lsb = ^w_redir_pc[1:0];

    always_comb begin
        pop  = (cnt_q != '0) & w_ready & ~w_redir;
        push = ~w_redir & ((cnt_q < CW'(DEPTH)) | pop);
    end

    always_comb begin
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        ent_pc_d = ent_pc_q;
        ent_ir_d = ent_ir_q;

        if (w_redir) begin
            pc_d     = {w_redir_pc[31:2], 2'b00};
            cnt_d    = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) begin
                ent_pc_d[wr_ptr_q] = pc_q;
                ent_ir_d[wr_ptr_q] = w_imem_data;
                pc_d               = pc_q + 32'd4;
                wr_ptr_d           = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            // Push and pop together leave occupancy unchanged, including when full.
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            pc_q     <= RESET_PC;
            cnt_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Entry storage needs no reset: outputs are masked whenever the queue is empty.
    always_ff @(posedge w_clk) begin
        ent_pc_q <= ent_pc_d;
        ent_ir_q <= ent_ir_d;
    end

    always_comb begin
        w_imem_addr = pc_q;
        w_count     = cnt_q;
        w_valid     = (cnt_q != '0);
        w_ir        = w_valid ? ent_ir_q[rd_ptr_q] : '0;
        w_pc        = w_valid ? ent_pc_q[rd_ptr_q] : '0;
    end

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (w_ready & ~w_valid & ~w_redir) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign w_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_m_fetch_queue.sv
// Directed bench for m_fetch_queue: stream, backpressure, full push/pop, redirect, reset priority, PC wrap.
module tb_m_fetch_queue;

    localparam logic [31:0] PAT = 32'hA5A50000;

    logic        w_clk;
    logic        w_rst;
    logic [31:0] w_imem_addr;
    logic [31:0] w_imem_data;
    logic        w_redir;
    logic [31:0] w_redir_pc;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_ir;
    logic [31:0] w_pc;
    logic [2:0]  w_count;
`ifdef FETCH_STALL_CNT_EN
    logic [31:0] w_stall_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    m_fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0)
    ) u_dut (
        .w_clk       (w_clk),
        .w_rst       (w_rst),
        .w_imem_addr (w_imem_addr),
        .w_imem_data (w_imem_data),
        .w_redir     (w_redir),
        .w_redir_pc  (w_redir_pc),
        .w_valid     (w_valid),
        .w_ready     (w_ready),
        .w_ir        (w_ir),
        .w_pc        (w_pc),
        .w_count     (w_count)
`ifdef FETCH_STALL_CNT_EN
        ,
        .w_stall_cnt (w_stall_cnt)
`endif
    );

    assign w_imem_data = w_imem_addr ^ PAT;

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge w_clk);
        #1;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] exp_pc);
        chk({tag, "_valid"}, {31'b0, w_valid}, 32'd1);
        chk({tag, "_pc"}, w_pc, exp_pc);
        chk({tag, "_ir"}, w_ir, exp_pc ^ PAT);
    endtask

    initial begin
        w_rst      = 1'b1;
        w_redir    = 1'b0;
        w_redir_pc = 32'h0;
        w_ready    = 1'b1;
        repeat (3) step();

        chk("rst_valid", {31'b0, w_valid}, 32'd0);
        chk("rst_ir", w_ir, 32'h0);
        chk("rst_pc", w_pc, 32'h0);
        chk("rst_count", {29'b0, w_count}, 32'd0);
        chk("rst_addr", w_imem_addr, 32'h0);

        // Stream with w_ready held high.
        w_rst = 1'b0;
        chk("first_fetch_addr", w_imem_addr, 32'h0);
        chk("first_fetch_valid", {31'b0, w_valid}, 32'd0);
        step();
        chk_head("stream0", 32'h0);
        chk("stream0_count", {29'b0, w_count}, 32'd1);
        chk("stream0_addr", w_imem_addr, 32'h4);
`ifdef FETCH_STALL_CNT_EN
        chk("stall_first", w_stall_cnt, 32'd1);
`endif
        for (int k = 1; k <= 5; k++) begin
            step();
            chk_head("stream", 32'(4 * k));
            chk("stream_count", {29'b0, w_count}, 32'd1);
        end

        // Backpressure from a fresh reset.
        w_rst = 1'b1;
        step();
        w_rst   = 1'b0;
        w_ready = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            chk("bp_count", {29'b0, w_count}, (i < 4) ? 32'(i) : 32'd4);
            chk_head("bp_head", 32'h0);
        end
        chk("bp_addr", w_imem_addr, 32'd16);

        // Full queue with push+pop each cycle: head advances, count stays at DEPTH.
        w_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk_head("drain", 32'(4 * i));
            chk("drain_count", {29'b0, w_count}, 32'd4);
            chk("drain_addr", w_imem_addr, 32'(16 + 4 * i));
        end

        w_ready = 1'b0;
        step();
        step();
        chk_head("hold", 32'd20);
        chk("hold_count", {29'b0, w_count}, 32'd4);

        // Redirect while full: low address bits dropped, queue flushed.
        w_redir    = 1'b1;
        w_redir_pc = 32'h103;
        w_ready    = 1'b1;
        step();
        w_redir = 1'b0;
        chk("redir_valid", {31'b0, w_valid}, 32'd0);
        chk("redir_count", {29'b0, w_count}, 32'd0);
        chk("redir_addr", w_imem_addr, 32'h100);
        chk("redir_pc_empty", w_pc, 32'h0);
        chk("redir_ir_empty", w_ir, 32'h0);
        step();
        chk_head("redir_t0", 32'h100);
        chk("redir_t0_count", {29'b0, w_count}, 32'd1);
`ifdef FETCH_STALL_CNT_EN
        chk("stall_redir", w_stall_cnt, 32'd1);
`endif
        step();
        chk_head("redir_t1", 32'h104);

        // Reset wins over a simultaneous redirect and discards queued entries.
        w_rst      = 1'b1;
        w_redir    = 1'b1;
        w_redir_pc = 32'h40;
        step();
        w_rst   = 1'b0;
        w_redir = 1'b0;
        chk("rst_redir_addr", w_imem_addr, 32'h0);
        chk("rst_redir_valid", {31'b0, w_valid}, 32'd0);

        // PC wrap past 2^32.
        w_redir    = 1'b1;
        w_redir_pc = 32'hFFFFFFF8;
        step();
        w_redir = 1'b0;
        chk("wrap_addr", w_imem_addr, 32'hFFFFFFF8);
        step();
        chk_head("wrap0", 32'hFFFFFFF8);
        step();
        chk_head("wrap1", 32'hFFFFFFFC);
        step();
        chk_head("wrap2", 32'h0);
        step();
        chk_head("wrap3", 32'h4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
